// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_rr_arbiter                                                 |
// | Purpose  : Round-robin arbiter sharing one registered AXI-Stream output    |
// |            slice among N_SRC producers. A source holds the grant for at    |
// |            most BURST_LEN beats, or until it leaves a gap while the slice  |
// |            could take a beat. Every grant costs one IDLE decision cycle.   |
// | Ports    : clk        rising-edge clock                                   |
// |            reset_n    asynchronous active-low reset                       |
// |            s_tdata    packed source data, source i at [i*DW +: DW]        |
// |            s_tvalid   per-source valid                                    |
// |            s_tready   per-source ready, one-hot or zero                   |
// |            m_tdata    registered output data                              |
// |            m_tvalid   registered output valid                             |
// |            m_tready   downstream ready                                    |
// |            grant_id   current / last granted source                       |
// |            busy       high while a source holds the grant                 |
// |            grant_cnt  per-source grant counters (AXIS_ARB_STATS_EN only)  |
// | Options  : `define AXIS_ARB_STATS_EN adds saturating per-source counters   |
// |            of IDLE->GRANT entries; datapath timing is unchanged.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module axis_rr_arbiter #(
    parameter int N_SRC     = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_SRC*DW-1:0]        s_tdata,
    input  logic [N_SRC-1:0]           s_tvalid,
    output logic [N_SRC-1:0]           s_tready,
    output logic [DW-1:0]              m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [$clog2(N_SRC)-1:0]   grant_id,
    output logic                       busy
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [N_SRC*CNT_W-1:0]     grant_cnt
`endif
);

    localparam int c_gw = $clog2(N_SRC);
    // One extra bit so grant_id + k (k up to N_SRC) never overflows before the wrap.
    localparam int c_iw = c_gw + 1;
    localparam int c_bw = $clog2(BURST_LEN + 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    localparam logic [c_bw-1:0] c_last_beat = c_bw'(BURST_LEN - 1);

    generate
        if (N_SRC < 2 || N_SRC > 8 || DW < 1 || BURST_LEN < 1 || CNT_W < 1) begin : g_param_check
            $error("axis_rr_arbiter: parameter out of range");
        end
    endgenerate

    logic [0:0]      r_state;
    logic [c_gw-1:0] r_grant_id;
    logic [c_bw-1:0] r_beat_cnt;
    logic [DW-1:0]   r_m_tdata;
    logic            r_m_tvalid;

    logic [0:0]      w_state_nxt;
    logic [c_gw-1:0] w_grant_id_nxt;
    logic [c_bw-1:0] w_beat_cnt_nxt;
    logic [DW-1:0]   w_m_tdata_nxt;
    logic            w_m_tvalid_nxt;

    logic            w_slot;
    logic            w_g_valid;
    logic            w_accept;
    logic            w_any_req;
    logic            w_grant_start;
    logic [c_gw-1:0] w_pick;
    logic [c_iw-1:0] w_idx;
    logic [DW-1:0]   w_src_data [N_SRC];

    // Unpack the flat data bus so the granted lane can be indexed directly.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_src_data[i] = s_tdata[i*DW +: DW];
        end
    end

    // Rotating scan starting just after the last grant. Iterating from the far
    // end of the scan back towards the near end lets the nearest requester win.
    always_comb begin
        w_pick    = r_grant_id;
        w_any_req = 1'b0;
        w_idx     = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            w_idx = {1'b0, r_grant_id} + c_iw'(k);
            if (w_idx >= c_iw'(N_SRC)) begin
                w_idx = w_idx - c_iw'(N_SRC);
            end
            if (s_tvalid[w_idx[c_gw-1:0]]) begin
                w_pick    = w_idx[c_gw-1:0];
                w_any_req = 1'b1;
            end
        end
    end

    assign w_slot    = ~r_m_tvalid | m_tready;
    assign w_g_valid = s_tvalid[r_grant_id];

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        w_m_tdata_nxt  = r_m_tdata;
        w_m_tvalid_nxt = r_m_tvalid;
        w_accept       = 1'b0;
        w_grant_start  = 1'b0;
        s_tready       = '0;

        case (r_state)
            c_st_idle: begin
                if (m_tready) begin
                    w_m_tvalid_nxt = 1'b0;
                end
                if (w_any_req) begin
                    w_state_nxt    = c_st_grant;
                    w_grant_id_nxt = w_pick;
                    w_beat_cnt_nxt = '0;
                    w_grant_start  = 1'b1;
                end
            end
            c_st_grant: begin
                s_tready[r_grant_id] = w_slot;
                w_accept             = w_g_valid & w_slot;
                if (w_accept) begin
                    w_m_tdata_nxt  = w_src_data[r_grant_id];
                    w_m_tvalid_nxt = 1'b1;
                    w_beat_cnt_nxt = r_beat_cnt + c_bw'(1);
                    if (r_beat_cnt == c_last_beat) begin
                        w_state_nxt = c_st_idle;
                    end
                end else begin
                    if (m_tready) begin
                        w_m_tvalid_nxt = 1'b0;
                    end
                    // A gap only ends the grant when the slice could have taken
                    // a beat; a stalled downstream never forces a release.
                    if (w_slot) begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_grant_id <= c_gw'(N_SRC - 1);
            r_beat_cnt <= '0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_m_tdata  <= w_m_tdata_nxt;
            r_m_tvalid <= w_m_tvalid_nxt;
        end
    end

    assign m_tdata  = r_m_tdata;
    assign m_tvalid = r_m_tvalid;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == c_st_grant);

`ifdef AXIS_ARB_STATS_EN
    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_stats
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (w_grant_start && (w_pick == c_gw'(i)) && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign grant_cnt[i*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axis_rr_arbiter                                              |
// | Purpose  : Self-checking bench for axis_rr_arbiter: a vector table for a   |
// |            single streaming source, hand sequences for rotation,           |
// |            backpressure, source gap and reset mid-burst, and a random      |
// |            phase compared against a behavioural reference model.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axis_rr_arbiter;

    localparam int N_SRC     = 4;
    localparam int DW        = 8;
    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 16;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N_SRC*DW-1:0]    s_tdata = '0;
    logic [N_SRC-1:0]       s_tvalid = '0;
    logic [N_SRC-1:0]       s_tready;
    logic [DW-1:0]          m_tdata;
    logic                   m_tvalid;
    logic                   m_tready = 1'b0;
    logic [1:0]             grant_id;
    logic                   busy;
`ifdef AXIS_ARB_STATS_EN
    logic [N_SRC*CNT_W-1:0] grant_cnt;
`endif

    axis_rr_arbiter #(
        .N_SRC     (N_SRC),
        .DW        (DW),
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef AXIS_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: arbitration as "first requester after the pointer",
    // the output slice as a single valid/data holding register.
    // ------------------------------------------------------------------
    bit         md_busy;
    int         md_gid;
    int         md_beats;
    bit         md_ov;
    logic [7:0] md_od;
    int         md_cnt [N_SRC];

    task automatic model_reset();
        md_busy  = 0;
        md_gid   = N_SRC - 1;
        md_beats = 0;
        md_ov    = 0;
        md_od    = '0;
        for (int i = 0; i < N_SRC; i++) md_cnt[i] = 0;
    endtask

    function automatic logic [N_SRC-1:0] model_tready(input logic mr);
        logic [N_SRC-1:0] r;
        r = '0;
        if (md_busy && (!md_ov || mr)) r[md_gid] = 1'b1;
        return r;
    endfunction

    task automatic model_step(input logic [N_SRC-1:0] v, input logic [N_SRC*DW-1:0] d, input logic mr);
        bit slot;
        slot = !md_ov || mr;
        if (!md_busy) begin
            if (mr) md_ov = 0;
            for (int k = 1; k <= N_SRC; k++) begin
                int c;
                c = (md_gid + k) % N_SRC;
                if (v[c]) begin
                    md_gid   = c;
                    md_busy  = 1;
                    md_beats = 0;
                    if (md_cnt[c] < (2 ** CNT_W) - 1) md_cnt[c]++;
                    break;
                end
            end
        end else if (v[md_gid] && slot) begin
            md_ov = 1;
            md_od = d[md_gid*DW +: DW];
            md_beats++;
            if (md_beats == BURST_LEN) md_busy = 0;
        end else begin
            if (mr) md_ov = 0;
            if (slot) md_busy = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Vector table: source 1 streams 0x68,01..05 with m_tready=1.
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] vld;
        logic [7:0] d1;
        logic       mr;
        logic [3:0] e_rdy;
        logic       e_mv;
        logic [7:0] e_md;
        logic       e_busy;
        logic [1:0] e_gid;
    } vec_t;

    vec_t tbl [10];

    // Source-side state for the random phase.
    bit         pend  [N_SRC];
    logic [7:0] pdata [N_SRC];
    int         seq   [N_SRC];

    initial begin
        logic [7:0] got[$];
        logic [1:0] gorder[$];
        int         k[N_SRC];
        bit         prev_busy;
        bit         found;
        logic [N_SRC-1:0] exp_rdy;

        tbl[0] = '{4'b0010, 8'h68, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3};
        tbl[1] = '{4'b0010, 8'h68, 1'b1, 4'b0010, 1'b0, 8'h00, 1'b1, 2'd1};
        tbl[2] = '{4'b0010, 8'h01, 1'b1, 4'b0010, 1'b1, 8'h68, 1'b1, 2'd1};
        tbl[3] = '{4'b0010, 8'h02, 1'b1, 4'b0010, 1'b1, 8'h01, 1'b1, 2'd1};
        tbl[4] = '{4'b0010, 8'h03, 1'b1, 4'b0010, 1'b1, 8'h02, 1'b1, 2'd1};
        tbl[5] = '{4'b0010, 8'h04, 1'b1, 4'b0000, 1'b1, 8'h03, 1'b0, 2'd1};
        tbl[6] = '{4'b0010, 8'h04, 1'b1, 4'b0010, 1'b0, 8'h03, 1'b1, 2'd1};
        tbl[7] = '{4'b0010, 8'h05, 1'b1, 4'b0010, 1'b1, 8'h04, 1'b1, 2'd1};
        tbl[8] = '{4'b0000, 8'h00, 1'b1, 4'b0010, 1'b1, 8'h05, 1'b1, 2'd1};
        tbl[9] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h05, 1'b0, 2'd1};

        // ---------------- reset values ----------------
        do_reset();
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 3);

        // ---------------- table: single source 1 ----------------
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            s_tvalid = tbl[r].vld;
            s_tdata  = {8'h00, 8'h00, tbl[r].d1, 8'h00};
            m_tready = tbl[r].mr;
            #1;
            chk($sformatf("tbl%0d_s_tready", r), s_tready, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_m_tvalid", r), m_tvalid, tbl[r].e_mv);
            chk($sformatf("tbl%0d_m_tdata", r), m_tdata, tbl[r].e_md);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            chk($sformatf("tbl%0d_grant_id", r), grant_id, tbl[r].e_gid);
        end

        // ---------------- all sources, rotation 0,1,2,3,0 ----------------
        do_reset();
        for (int i = 0; i < N_SRC; i++) k[i] = 0;
        prev_busy = 0;
        for (int cyc = 0; cyc < 60 && got.size() < 20; cyc++) begin
            @(negedge clk);
            s_tvalid = '1;
            m_tready = 1'b1;
            for (int i = 0; i < N_SRC; i++) s_tdata[i*DW +: DW] = 8'(16 * i + k[i]);
            #1;
            if (m_tvalid) got.push_back(m_tdata);
            if (busy && !prev_busy) gorder.push_back(grant_id);
            prev_busy = busy;
            for (int i = 0; i < N_SRC; i++) if (s_tready[i]) k[i]++;
        end
        chk("rot_beat_count", got.size(), 20);
        for (int j = 0; j < 20 && j < got.size(); j++) begin
            chk($sformatf("rot_beat%0d", j), got[j], 8'(16 * ((j / 4) % 4) + ((j / 16) * 4) + (j % 4)));
        end
        chk("rot_grant_count_ge5", (gorder.size() >= 5) ? 1 : 0, 1);
        for (int j = 0; j < 5 && j < gorder.size(); j++) begin
            chk($sformatf("rot_grant%0d", j), gorder[j], j % 4);
        end

        // ---------------- backpressure on source 2, then reset mid-burst ----------------
        do_reset();
        found = 0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            s_tvalid = 4'b0100;
            s_tdata  = {8'h00, 8'hA0, 8'h00, 8'h00};
            m_tready = 1'b1;
            #1;
            if (s_tready[2]) found = 1;
        end
        chk("bp_grant_seen", found, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            s_tdata  = {8'h00, 8'hA1, 8'h00, 8'h00};
            m_tready = 1'b0;
            #1;
            chk($sformatf("bp%0d_m_tvalid", c), m_tvalid, 1);
            chk($sformatf("bp%0d_m_tdata", c), m_tdata, 8'hA0);
            chk($sformatf("bp%0d_s_tready", c), s_tready, 0);
            chk($sformatf("bp%0d_busy", c), busy, 1);
        end
        @(negedge clk);
        m_tready = 1'b1;
        #1;
        chk("bp_resume_s_tready", s_tready, 4'b0100);
        @(negedge clk);
        #1;
        chk("bp_resume_m_tdata", m_tdata, 8'hA1);
        chk("bp_resume_m_tvalid", m_tvalid, 1);
        chk("bp_resume_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_m_tvalid", m_tvalid, 0);
        chk("rstmid_s_tready", s_tready, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_grant_id", grant_id, 3);
        @(negedge clk);
        reset_n = 1'b1;
        s_tvalid = '0;

        // ---------------- source gap on source 3, source 0 next ----------------
        do_reset();
        @(negedge clk);
        s_tvalid = 4'b1000;
        s_tdata  = {8'hC0, 8'h00, 8'h00, 8'h0A};
        m_tready = 1'b1;
        #1;
        chk("gap_c0_busy", busy, 0);
        @(negedge clk);
        s_tvalid = 4'b1001;
        #1;
        chk("gap_c1_busy", busy, 1);
        chk("gap_c1_grant_id", grant_id, 3);
        chk("gap_c1_s_tready", s_tready, 4'b1000);
        @(negedge clk);
        s_tdata = {8'hC1, 8'h00, 8'h00, 8'h0A};
        #1;
        chk("gap_c2_s_tready", s_tready, 4'b1000);
        chk("gap_c2_m_tdata", m_tdata, 8'hC0);
        @(negedge clk);
        s_tvalid = 4'b0001;
        #1;
        chk("gap_c3_busy", busy, 1);
        chk("gap_c3_m_tdata", m_tdata, 8'hC1);
        @(negedge clk);
        #1;
        chk("gap_c4_busy", busy, 0);
        chk("gap_c4_m_tvalid", m_tvalid, 0);
        @(negedge clk);
        #1;
        chk("gap_c5_busy", busy, 1);
        chk("gap_c5_grant_id", grant_id, 0);
        chk("gap_c5_s_tready", s_tready, 4'b0001);
        @(negedge clk);
        #1;
        chk("gap_c6_m_tdata", m_tdata, 8'h0A);

        // ---------------- random phase against the reference model ----------------
        do_reset();
        for (int i = 0; i < N_SRC; i++) begin
            pend[i] = 0;
            seq[i]  = 0;
            pdata[i] = '0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N_SRC; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 55)) begin
                    pend[i]  = 1;
                    pdata[i] = 8'(i * 64 + (seq[i] % 64));
                    seq[i]++;
                end
                s_tvalid[i]          = pend[i];
                s_tdata[i*DW +: DW]  = pdata[i];
            end
            m_tready = ($urandom_range(0, 99) < 70);
            #1;
            exp_rdy = model_tready(m_tready);
            chk($sformatf("rnd%0d_s_tready", cyc), s_tready, exp_rdy);
            chk($sformatf("rnd%0d_m_tvalid", cyc), m_tvalid, md_ov);
            chk($sformatf("rnd%0d_m_tdata", cyc), m_tdata, md_od);
            chk($sformatf("rnd%0d_busy", cyc), busy, md_busy);
            chk($sformatf("rnd%0d_grant_id", cyc), grant_id, md_gid);
            model_step(s_tvalid, s_tdata, m_tready);
            for (int i = 0; i < N_SRC; i++) if (exp_rdy[i] && pend[i]) pend[i] = 0;
        end
`ifdef AXIS_ARB_STATS_EN
        #1;
        for (int i = 0; i < N_SRC; i++) begin
            chk($sformatf("stats_grant_cnt%0d", i), grant_cnt[i*CNT_W +: CNT_W], md_cnt[i]);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
